// File: rtl/tamper_event_monitor.sv
// tamper_event_monitor: synchronises asynchronous tamper flags, keeps sticky
// status and a saturating event count, and escalates through alert, lockdown
// and zeroize. Drives the LOCKDOWN_ALL_N / ZEROIZE_N inputs of the TAMPER macro.
//
// Request semantics: CLEAR and ACK are single-cycle requests sampled on the
// rising CLK edge; there is no ready/response. A request is either acted on in
// that cycle or dropped (CLEAR in LOCKDOWN without UNLOCK_EN, CLEAR/ACK in
// ZEROIZE and HALT). Nothing is queued.
module tamper_event_monitor #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int LOCK_THRESH = 4,
  parameter int ZERO_THRESH = 16,
  parameter int ZERO_PULSE  = 4,
  parameter int UNLOCK_EN   = 0,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_SRC-1:0]   TAMPER_IN,
  input  logic [NUM_SRC-1:0]   TAMPER_EN,
  input  logic [3:0]           DETECT_CATEGORY,
  input  logic                 TAMPER_CHANGE_STROBE,
  input  logic                 CLEAR,
  input  logic                 ACK,
  output logic [NUM_SRC-1:0]   EVENT_STICKY,
  output logic [CNT_WIDTH-1:0] EVENT_COUNT,
  output logic [SRC_W-1:0]     LAST_SRC,
  output logic [3:0]           LAST_CATEGORY,
  output logic                 IRQ,
  output logic                 LOCKDOWN_ALL_N,
  output logic                 ZEROIZE_N,
  output logic [2:0]           STATE
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALERT    = 3'd1,
    ST_LOCKDOWN = 3'd2,
    ST_ZEROIZE  = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam int ZW = (ZERO_PULSE > 1) ? $clog2(ZERO_PULSE) : 1;
  localparam logic [ZW-1:0]        ZP_LOAD = ZW'(ZERO_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] LOCK_T  = CNT_WIDTH'(LOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] ZERO_T  = CNT_WIDTH'(ZERO_THRESH);

  // Synchroniser chains and edge-detect history
  logic [NUM_SRC-1:0]     tin_sync [SYNC_STAGES];
  logic [3:0]             cat_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] stb_sync;
  logic [NUM_SRC-1:0]     tin_prev;
  logic                   stb_prev;

  // Registered state
  state_t                 state_q, state_next;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_next, base_cnt;
  logic [NUM_SRC-1:0]     sticky_q, sticky_next, base_sticky;
  logic [SRC_W-1:0]       src_q, src_next;
  logic [ZW-1:0]          zcnt_q, zcnt_next;
  logic [3:0]             cat_q;
  logic                   irq_q, lock_n_q, zero_n_q;

  // Combinational helpers
  logic [NUM_SRC-1:0]     ev;
  logic                   any_ev, stb_rise, clear_ok, hit_zero, hit_lock;
  state_t                 esc_state;

  // Input synchronisers; DETECT_CATEGORY rides alongside the strobe so both
  // reach the last stage in the same cycle. Flags high at reset release
  // look like a rising edge because the history flops reset to 0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        tin_sync[s] <= '0;
        cat_sync[s] <= '0;
      end
      stb_sync <= '0;
      tin_prev <= '0;
      stb_prev <= 1'b0;
    end else begin
      tin_sync[0] <= TAMPER_IN;
      cat_sync[0] <= DETECT_CATEGORY;
      stb_sync[0] <= TAMPER_CHANGE_STROBE;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        tin_sync[s] <= tin_sync[s-1];
        cat_sync[s] <= cat_sync[s-1];
        stb_sync[s] <= stb_sync[s-1];
      end
      tin_prev <= tin_sync[SYNC_STAGES-1];
      stb_prev <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign ev       = tin_sync[SYNC_STAGES-1] & ~tin_prev & TAMPER_EN;
  assign any_ev   = |ev;
  assign stb_rise = stb_sync[SYNC_STAGES-1] & ~stb_prev;

  // Next-state, counter and status update; clear is applied before the event
  always_comb begin
    state_next  = state_q;
    zcnt_next   = zcnt_q;
    src_next    = src_q;
    clear_ok    = CLEAR && ((state_q == ST_IDLE) || (state_q == ST_ALERT) ||
                            ((state_q == ST_LOCKDOWN) && (UNLOCK_EN != 0)));
    base_cnt    = clear_ok ? '0 : cnt_q;
    base_sticky = clear_ok ? '0 : sticky_q;
    cnt_next    = base_cnt;
    if (any_ev && (base_cnt != CNT_MAX)) cnt_next = base_cnt + CNT_WIDTH'(1);
    sticky_next = base_sticky | ev;

    // Lowest set index wins: scan from the top so the last hit is the lowest
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (ev[i]) src_next = SRC_W'(i);
    end

    hit_zero  = (cnt_next >= ZERO_T);
    hit_lock  = (cnt_next >= LOCK_T);
    esc_state = hit_zero ? ST_ZEROIZE : (hit_lock ? ST_LOCKDOWN : ST_ALERT);

    case (state_q)
      ST_IDLE: begin
        if (any_ev) state_next = esc_state;
      end
      ST_ALERT: begin
        if (any_ev)            state_next = esc_state;
        else if (ACK || CLEAR) state_next = ST_IDLE;
      end
      ST_LOCKDOWN: begin
        if (any_ev && hit_zero) state_next = ST_ZEROIZE;
        else if (clear_ok)      state_next = any_ev ? esc_state : ST_IDLE;
      end
      ST_ZEROIZE: begin
        if (zcnt_q == '0) state_next = ST_HALT;
        else              zcnt_next  = zcnt_q - ZW'(1);
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Arm the pulse counter on entry so ZEROIZE lasts exactly ZERO_PULSE cycles
    if ((state_next == ST_ZEROIZE) && (state_q != ST_ZEROIZE)) zcnt_next = ZP_LOAD;
  end

  // State, status and registered output decode of the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sticky_q <= '0;
      src_q    <= '0;
      zcnt_q   <= '0;
      cat_q    <= '0;
      irq_q    <= 1'b0;
      lock_n_q <= 1'b1;
      zero_n_q <= 1'b1;
    end else begin
      state_q  <= state_next;
      cnt_q    <= cnt_next;
      sticky_q <= sticky_next;
      src_q    <= src_next;
      zcnt_q   <= zcnt_next;
      if (stb_rise) cat_q <= cat_sync[SYNC_STAGES-1];
      irq_q    <= (state_next != ST_IDLE);
      lock_n_q <= !((state_next == ST_LOCKDOWN) || (state_next == ST_ZEROIZE) ||
                    (state_next == ST_HALT));
      zero_n_q <= (state_next != ST_ZEROIZE);
    end
  end

  assign EVENT_STICKY   = sticky_q;
  assign EVENT_COUNT    = cnt_q;
  assign LAST_SRC       = src_q;
  assign LAST_CATEGORY  = cat_q;
  assign IRQ            = irq_q;
  assign LOCKDOWN_ALL_N = lock_n_q;
  assign ZEROIZE_N      = zero_n_q;
  assign STATE          = state_q;

endmodule

// File: tb/tb_tamper_event_monitor.sv
// Directed bench for tamper_event_monitor. dut_a uses the default parameters,
// dut_b is identical but with UNLOCK_EN=1, dut_c has a 2-bit counter with
// LOCK/ZERO thresholds of 3. All three share the same stimulus.
module tb_tamper_event_monitor;

  logic       clk;
  logic       rst_n;
  logic [7:0] tin;
  logic [7:0] ten;
  logic [3:0] cat;
  logic       strobe;
  logic       clear;
  logic       ack;

  logic [7:0] a_sticky, b_sticky, c_sticky;
  logic [7:0] a_count, b_count;
  logic [1:0] c_count;
  logic [2:0] a_src, b_src, c_src;
  logic [3:0] a_cat, b_cat, c_cat;
  logic       a_irq, b_irq, c_irq;
  logic       a_lock_n, b_lock_n, c_lock_n;
  logic       a_zero_n, b_zero_n, c_zero_n;
  logic [2:0] a_state, b_state, c_state;

  int n_cmp = 0;
  int n_err = 0;
  int low_cnt;

  tamper_event_monitor dut_a (
    .CLK(clk), .RESET_N(rst_n), .TAMPER_IN(tin), .TAMPER_EN(ten),
    .DETECT_CATEGORY(cat), .TAMPER_CHANGE_STROBE(strobe), .CLEAR(clear), .ACK(ack),
    .EVENT_STICKY(a_sticky), .EVENT_COUNT(a_count), .LAST_SRC(a_src),
    .LAST_CATEGORY(a_cat), .IRQ(a_irq), .LOCKDOWN_ALL_N(a_lock_n),
    .ZEROIZE_N(a_zero_n), .STATE(a_state)
  );

  tamper_event_monitor #(.UNLOCK_EN(1)) dut_b (
    .CLK(clk), .RESET_N(rst_n), .TAMPER_IN(tin), .TAMPER_EN(ten),
    .DETECT_CATEGORY(cat), .TAMPER_CHANGE_STROBE(strobe), .CLEAR(clear), .ACK(ack),
    .EVENT_STICKY(b_sticky), .EVENT_COUNT(b_count), .LAST_SRC(b_src),
    .LAST_CATEGORY(b_cat), .IRQ(b_irq), .LOCKDOWN_ALL_N(b_lock_n),
    .ZEROIZE_N(b_zero_n), .STATE(b_state)
  );

  tamper_event_monitor #(.CNT_WIDTH(2), .LOCK_THRESH(3), .ZERO_THRESH(3)) dut_c (
    .CLK(clk), .RESET_N(rst_n), .TAMPER_IN(tin), .TAMPER_EN(ten),
    .DETECT_CATEGORY(cat), .TAMPER_CHANGE_STROBE(strobe), .CLEAR(clear), .ACK(ack),
    .EVENT_STICKY(c_sticky), .EVENT_COUNT(c_count), .LAST_SRC(c_src),
    .LAST_CATEGORY(c_cat), .IRQ(c_irq), .LOCKDOWN_ALL_N(c_lock_n),
    .ZEROIZE_N(c_zero_n), .STATE(c_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tin    = '0;
    clear  = 1'b0;
    ack    = 1'b0;
    strobe = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // One-cycle pulse on a source; returns once the event is visible
  task automatic fire(input int i);
    tin[i] = 1'b1;
    step(1);
    tin[i] = 1'b0;
    step(3);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_sticky"}, a_sticky, 0);
    check({tag, "_count"},  a_count,  0);
    check({tag, "_src"},    a_src,    0);
    check({tag, "_cat"},    a_cat,    0);
    check({tag, "_irq"},    a_irq,    0);
    check({tag, "_lock_n"}, a_lock_n, 1);
    check({tag, "_zero_n"}, a_zero_n, 1);
    check({tag, "_state"},  a_state,  0);
  endtask

  initial begin
    ten    = '1;
    cat    = '0;
    rst_n  = 1'b0;
    tin    = '0;
    clear  = 1'b0;
    ack    = 1'b0;
    strobe = 1'b0;
    step(2);
    check_a_reset("rst");
    rst_n = 1'b1;
    step(1);

    // 1: single source, latency and ACK
    tin[3] = 1'b1;
    step(2);
    check("t1_early_count", a_count, 0);
    step(1);
    check("t1_sticky", a_sticky, 8'h08);
    check("t1_count",  a_count,  1);
    check("t1_src",    a_src,    3);
    check("t1_irq",    a_irq,    1);
    check("t1_state",  a_state,  1);
    step(7);
    tin[3] = 1'b0;
    step(3);
    check("t1_held_count", a_count, 1);
    pulse_ack();
    check("t1_ack_state",  a_state,  0);
    check("t1_ack_irq",    a_irq,    0);
    check("t1_ack_sticky", a_sticky, 8'h08);

    // 2: two sources in the same cycle
    pulse_clear();
    check("t2_clr_count",  a_count,  0);
    check("t2_clr_sticky", a_sticky, 0);
    check("t2_clr_src",    a_src,    3);
    tin[1] = 1'b1;
    tin[5] = 1'b1;
    step(1);
    tin[1] = 1'b0;
    tin[5] = 1'b0;
    step(3);
    check("t2_count",  a_count,  1);
    check("t2_src",    a_src,    1);
    check("t2_sticky", a_sticky, 8'h22);

    // 3: lockdown and UNLOCK_EN
    do_reset();
    fire(0);
    fire(1);
    fire(2);
    check("t3_alert_state", a_state, 1);
    check("t3_alert_count", a_count, 3);
    fire(3);
    check("t3_lock_state",  a_state,  2);
    check("t3_lock_n",      a_lock_n, 0);
    check("t3_lock_irq",    a_irq,    1);
    check("t3_lock_count",  a_count,  4);
    pulse_ack();
    check("t3_ack_state",   a_state,  2);
    pulse_clear();
    check("t3_a_clr_state", a_state,  2);
    check("t3_a_clr_count", a_count,  4);
    check("t3_a_clr_lock",  a_lock_n, 0);
    check("t3_b_clr_state", b_state,  0);
    check("t3_b_clr_count", b_count,  0);
    check("t3_b_clr_lock",  b_lock_n, 1);
    check("t3_b_clr_irq",   b_irq,    0);

    // 4: zeroize pulse, halt, reset out of halt
    do_reset();
    repeat (15) fire(0);
    check("t4_pre_count", a_count, 15);
    check("t4_pre_state", a_state, 2);
    tin[0] = 1'b1;
    step(1);
    tin[0] = 1'b0;
    step(2);
    check("t4_z_state",  a_state,  3);
    check("t4_z_count",  a_count,  16);
    check("t4_z_zero_n", a_zero_n, 0);
    check("t4_z_lock_n", a_lock_n, 0);
    low_cnt = 1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (a_zero_n == 1'b0) low_cnt++;
    end
    check("t4_z_width",   low_cnt,  4);
    check("t4_h_state",   a_state,  4);
    check("t4_h_lock_n",  a_lock_n, 0);
    check("t4_h_zero_n",  a_zero_n, 1);
    check("t4_h_irq",     a_irq,    1);
    pulse_clear();
    check("t4_h_clr_state", a_state, 4);
    check("t4_h_clr_count", a_count, 16);
    rst_n = 1'b0;
    #1;
    check_a_reset("t4_rst");
    step(1);
    rst_n = 1'b1;
    step(1);

    // 5: disabled source, clear coincident with event, enable drop keeps sticky
    ten[2] = 1'b0;
    repeat (3) begin
      tin[2] = 1'b1;
      step(2);
      tin[2] = 1'b0;
      step(2);
    end
    step(3);
    check("t5_dis_sticky", a_sticky, 0);
    check("t5_dis_count",  a_count,  0);
    check("t5_dis_state",  a_state,  0);
    ten = '1;
    fire(4);
    check("t5_pre_sticky", a_sticky, 8'h10);
    tin[0] = 1'b1;
    step(1);
    tin[0] = 1'b0;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("t5_cc_sticky", a_sticky, 8'h01);
    check("t5_cc_count",  a_count,  1);
    check("t5_cc_src",    a_src,    0);
    check("t5_cc_state",  a_state,  1);
    ten[0] = 1'b0;
    step(2);
    check("t5_en_off_sticky", a_sticky, 8'h01);
    ten = '1;

    // 6: small counter, direct IDLE->ZEROIZE, saturation, category strobe
    do_reset();
    fire(0);
    fire(1);
    check("t6_c_count2", c_count, 2);
    check("t6_c_alert",  c_state, 1);
    pulse_ack();
    check("t6_c_idle",   c_state, 0);
    tin[2] = 1'b1;
    step(1);
    tin[2] = 1'b0;
    step(2);
    check("t6_c_zstate", c_state,  3);
    check("t6_c_zcount", c_count,  3);
    check("t6_c_zero_n", c_zero_n, 0);
    fire(3);
    check("t6_c_sat1",   c_count, 3);
    check("t6_c_halt",   c_state, 4);
    fire(5);
    check("t6_c_sat2",   c_count,  3);
    check("t6_c_sticky", c_sticky, 8'h2F);
    check("t6_c_src",    c_src,    5);

    // reset in the middle of ZEROIZE releases ZEROIZE_N at once
    do_reset();
    fire(0);
    fire(1);
    tin[2] = 1'b1;
    step(1);
    tin[2] = 1'b0;
    step(2);
    check("t6_mid_zero_n", c_zero_n, 0);
    step(1);
    rst_n = 1'b0;
    #1;
    check("t6_mid_rst_zero_n", c_zero_n, 1);
    check("t6_mid_rst_lock_n", c_lock_n, 1);
    check("t6_mid_rst_state",  c_state,  0);
    step(1);
    rst_n = 1'b1;
    step(1);

    cat    = 4'hA;
    strobe = 1'b1;
    step(2);
    check("t6_cat_early", a_cat, 0);
    step(1);
    check("t6_cat_a",     a_cat, 4'hA);
    check("t6_cat_c",     c_cat, 4'hA);
    strobe = 1'b0;
    cat    = 4'h5;
    step(4);
    check("t6_cat_hold",  a_cat, 4'hA);
    strobe = 1'b1;
    step(3);
    check("t6_cat_5",     a_cat, 4'h5);
    strobe = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
